// File: rtl/mp3_ctrl_panel.sv
// Front-panel controls for the mp3 SPI player: debounces four raw buttons
// and produces the volume word, song-select level and pause level.
module mp3_ctrl_panel #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 2000000,
    parameter int unsigned REPEAT_CYCLES   = 500000,
    parameter logic [7:0]  VOL_STEP        = 8'h10,
    parameter logic [7:0]  MAX_ATT         = 8'hF0,
    parameter logic [7:0]  DEFAULT_ATT     = 8'h20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_up,
    input  logic        i_btn_dn,
    input  logic        i_btn_next,
    input  logic        i_btn_pause,
    output logic [15:0] o_vol,
    output logic        o_song_select,
    output logic        o_pause,
    output logic [3:0]  o_vol_level
);

    localparam int unsigned NB      = 4;
    localparam int unsigned B_UP    = 0;
    localparam int unsigned B_DN    = 1;
    localparam int unsigned B_NEXT  = 2;
    localparam int unsigned B_PAUSE = 3;
    localparam int unsigned DW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned TMAX    = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned TW      = (TMAX > 2) ? $clog2(TMAX) : 1;

    typedef enum logic [1:0] {
        V_IDLE,
        V_HOLD,
        V_REPEAT
    } vstate_t;

    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] stable;
    logic [NB-1:0] stable_d;
    logic [NB-1:0] press;
    logic [DW-1:0] dcnt [NB];

    vstate_t       state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic          dir, dir_n;
    logic [7:0]    att, att_n;
    logic          held;
    logic          both;

    assign raw = {i_btn_pause, i_btn_next, i_btn_dn, i_btn_up};

    // One saturating volume step; 9-bit sum so the quiet side cannot wrap.
    function automatic logic [7:0] step_att(input logic [7:0] a, input logic up);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, VOL_STEP};
        if (up) begin
            step_att = (a < VOL_STEP) ? 8'h00 : a - VOL_STEP;
        end else begin
            step_att = (sum > {1'b0, MAX_ATT}) ? MAX_ATT : sum[7:0];
        end
    endfunction

    // Synchronise, debounce and turn stable rising edges into one-cycle presses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            press    <= '0;
            for (int i = 0; i < NB; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            for (int i = 0; i < NB; i++) begin
                if (sync2[i] == stable[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= sync2[i];
                    dcnt[i]   <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + DW'(1);
                end
            end
        end
    end

    // Song toggles on next and always unpauses; next beats pause in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_song_select <= 1'b0;
            o_pause       <= 1'b0;
        end else if (press[B_NEXT]) begin
            o_song_select <= ~o_song_select;
            o_pause       <= 1'b0;
        end else if (press[B_PAUSE]) begin
            o_pause <= ~o_pause;
        end
    end

    assign held = dir ? stable[B_UP] : stable[B_DN];
    assign both = stable[B_UP] & stable[B_DN];

    // Volume FSM state, timer, latched direction and attenuation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= V_IDLE;
            tmr   <= '0;
            dir   <= 1'b0;
            att   <= DEFAULT_ATT;
        end else begin
            state <= state_n;
            tmr   <= tmr_n;
            dir   <= dir_n;
            att   <= att_n;
        end
    end

    // Volume FSM next state: first step on press, hold delay, then auto-repeat.
    always_comb begin
        state_n = state;
        tmr_n   = tmr;
        dir_n   = dir;
        att_n   = att;
        unique case (state)
            V_IDLE: begin
                if (press[B_UP] ^ press[B_DN]) begin
                    dir_n   = press[B_UP];
                    att_n   = step_att(att, press[B_UP]);
                    tmr_n   = TW'(HOLD_CYCLES - 1);
                    state_n = V_HOLD;
                end
            end
            V_HOLD, V_REPEAT: begin
                if (!held || both) begin
                    state_n = V_IDLE;
                end else if (tmr == '0) begin
                    att_n   = step_att(att, dir);
                    tmr_n   = TW'(REPEAT_CYCLES - 1);
                    state_n = V_REPEAT;
                end else begin
                    tmr_n = tmr - TW'(1);
                end
            end
            default: state_n = V_IDLE;
        endcase
    end

    assign o_vol       = {att, att};
    assign o_vol_level = att[7:4];

endmodule

// File: tb/tb_mp3_ctrl_panel.sv
// Bench for mp3_ctrl_panel: directed scenarios plus random button activity,
// checked every cycle against an event-level reference model.
module tb_mp3_ctrl_panel;

    localparam int D    = 4;
    localparam int H    = 20;
    localparam int R    = 8;
    localparam int DEF  = 32;
    localparam int STEP = 16;
    localparam int MAXA = 240;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        up  = 1'b0;
    logic        dn  = 1'b0;
    logic        nx  = 1'b0;
    logic        pa  = 1'b0;
    logic [15:0] o_vol;
    logic        o_song_select;
    logic        o_pause;
    logic [3:0]  o_vol_level;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    mp3_ctrl_panel #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R),
        .VOL_STEP       (8'h10),
        .MAX_ATT        (8'hF0),
        .DEFAULT_ATT    (8'h20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_btn_up     (up),
        .i_btn_dn     (dn),
        .i_btn_next   (nx),
        .i_btn_pause  (pa),
        .o_vol        (o_vol),
        .o_song_select(o_song_select),
        .o_pause      (o_pause),
        .o_vol_level  (o_vol_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a button's level is accepted once D consecutive samples
    // (seen through the two-stage input pipe) disagree with it; a press acts two
    // edges after acceptance. Volume steps are scheduled by absolute edge index.
    int m_att   = DEF;
    bit m_song  = 1'b0;
    bit m_pause = 1'b0;
    bit m_st   [4];
    bit m_hist [4][D+1];
    bit m_r1   [4];
    bit m_r2   [4];
    bit m_act   = 1'b0;
    bit m_dir   = 1'b0;
    int m_k     = 0;
    int m_next  = 0;

    function automatic int mstep(input int a, input bit u);
        if (u) return (a >= STEP) ? a - STEP : 0;
        return (a + STEP > MAXA) ? MAXA : a + STEP;
    endfunction

    always @(posedge clk) begin
        bit raw [4];
        bit pr  [4];
        bit all_opp;
        raw = '{up, dn, nx, pa};
        m_k++;
        if (rst) begin
            m_att   = DEF;
            m_song  = 1'b0;
            m_pause = 1'b0;
            m_act   = 1'b0;
            m_dir   = 1'b0;
            for (int b = 0; b < 4; b++) begin
                m_st[b] = 1'b0;
                m_r1[b] = 1'b0;
                m_r2[b] = 1'b0;
                for (int j = 0; j <= D; j++) m_hist[b][j] = 1'b0;
            end
        end else begin
            for (int b = 0; b < 4; b++) pr[b] = m_r2[b];
            if (m_act) begin
                if (!(m_dir ? m_st[0] : m_st[1]) || (m_st[0] && m_st[1])) begin
                    m_act = 1'b0;
                end else if (m_k == m_next) begin
                    m_att  = mstep(m_att, m_dir);
                    m_next = m_k + R;
                end
            end else if (pr[0] != pr[1]) begin
                m_dir  = pr[0];
                m_att  = mstep(m_att, pr[0]);
                m_act  = 1'b1;
                m_next = m_k + H;
            end
            if (pr[2]) begin
                m_song  = !m_song;
                m_pause = 1'b0;
            end else if (pr[3]) begin
                m_pause = !m_pause;
            end
            for (int b = 0; b < 4; b++) begin
                all_opp = 1'b1;
                for (int j = 1; j <= D; j++) if (m_hist[b][j] == m_st[b]) all_opp = 1'b0;
                m_r2[b] = m_r1[b];
                m_r1[b] = all_opp && !m_st[b];
                if (all_opp) m_st[b] = !m_st[b];
                for (int j = D; j >= 1; j--) m_hist[b][j] = m_hist[b][j-1];
                m_hist[b][0] = raw[b];
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_vol",   o_vol, {16'h0, m_att[7:0], m_att[7:0]});
            check("m_lvl",   o_vol_level, m_att / 16);
            check("m_song",  o_song_select, m_song);
            check("m_pause", o_pause, m_pause);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0: up = v;
            1: dn = v;
            2: nx = v;
            default: pa = v;
        endcase
    endtask

    task automatic press(input int b, input int len);
        set_btn(b, 1'b1);
        tick(len);
        set_btn(b, 1'b0);
        tick(12);
    endtask

    initial begin
        tick(3);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset
        tick(50);
        check("rst_vol",   o_vol, 16'h2020);
        check("rst_lvl",   o_vol_level, 4'd2);
        check("rst_song",  o_song_select, 1'b0);
        check("rst_pause", o_pause, 1'b0);

        // Single dn press, exact latency, then a short up bounce
        dn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 7) check("dn_e6", o_vol, 16'h2020);
            if (i == 8) check("dn_e7", o_vol, 16'h3030);
        end
        dn = 1'b0;
        tick(20);
        up = 1'b1;
        tick(3);
        up = 1'b0;
        tick(20);
        check("bounce", o_vol, 16'h3030);

        // Held up: first step, hold delay, repeat, saturation
        up = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick(1);
            if (i == 8)  check("hold_e7",  o_vol, 16'h2020);
            if (i == 27) check("hold_e26", o_vol, 16'h2020);
            if (i == 28) check("hold_e27", o_vol, 16'h1010);
            if (i == 35) check("rep_e34",  o_vol, 16'h1010);
            if (i == 36) check("rep_e35",  o_vol, 16'h0000);
            if (i == 60) check("sat_lo",   o_vol, 16'h0000);
        end
        up = 1'b0;
        tick(20);

        // Sixteen dn presses from default saturate at F0
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        check("rst2_vol", o_vol, 16'h2020);
        for (int i = 0; i < 16; i++) press(1, 6);
        check("sat_hi_vol", o_vol, 16'hF0F0);
        check("sat_hi_lvl", o_vol_level, 4'd15);

        // Pause / next interaction
        press(3, 6);
        check("pause_on", o_pause, 1'b1);
        press(2, 6);
        check("next_song",  o_song_select, 1'b1);
        check("next_pause", o_pause, 1'b0);
        pa = 1'b1;
        nx = 1'b1;
        tick(6);
        pa = 1'b0;
        nx = 1'b0;
        tick(12);
        check("both_song",  o_song_select, 1'b0);
        check("both_pause", o_pause, 1'b0);

        // Simultaneous up and dn are ignored
        up = 1'b1;
        dn = 1'b1;
        tick(40);
        check("updn_vol", o_vol, 16'hF0F0);
        up = 1'b0;
        dn = 1'b0;
        tick(20);
        check("updn_rel", o_vol, 16'hF0F0);

        // Reset during auto-repeat aborts the hold
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(2);
        dn = 1'b1;
        tick(40);
        check("rep_pre", o_vol, 16'h5050);
        rst = 1'b1;
        dn  = 1'b0;
        tick(1);
        rst = 1'b0;
        check("rst_rep", o_vol, 16'h2020);
        tick(40);
        check("no_step", o_vol, 16'h2020);
        press(1, 6);
        check("fresh", o_vol, 16'h3030);

        // Random button activity with occasional reset
        repeat (3000) begin
            tick(1);
            if ($urandom_range(11) == 0) up = ~up;
            if ($urandom_range(11) == 0) dn = ~dn;
            if ($urandom_range(11) == 0) nx = ~nx;
            if ($urandom_range(11) == 0) pa = ~pa;
            rst = ($urandom_range(399) == 0);
        end
        rst = 1'b0;
        up  = 1'b0;
        dn  = 1'b0;
        nx  = 1'b0;
        pa  = 1'b0;
        tick(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
